vga_sync_recovery: RTL
======================

// Module: vga_sync_recovery
// PURPOSE
//   Receive-side counterpart of the 640x480 timing generator. Samples incoming active-low
//   HSYNC/VSYNC on the pixel strobe, measures line and frame periods, and locks when
//   LOCK_FRAMES consecutive frames match nominal timing. While locked, regenerates pixel
//   x/y and active for downstream capture logic, e.g. frame grabber or loopback checker.
// PARAMETERS
//   LINE        800  nominal pixel strobes between consecutive HSYNC falling edges
//   SCREEN      525  nominal HSYNC falling edges per frame, VSYNC fall to VSYNC fall
//   HA_OFF      144  h_cnt value of first active pixel; h_cnt=0 on HSYNC fall strobe
//   VA_OFF      96   v_cnt value of first active line; v_cnt=0 on VSYNC fall strobe
//   H_ACTIVE    640  active pixels per line
//   V_ACTIVE    360  active lines per frame
//   LOCK_FRAMES 2    consecutive good frames required to assert lock (1..15)
// PORTS
//   i_clk           in   1   base clock
//   i_rst_n         in   1   asynchronous active-low reset
//   i_pix_stb       in   1   pixel clock strobe; all state advances only when high
//   i_hs            in   1   incoming horizontal sync, active low, asynchronous
//   i_vs            in   1   incoming vertical sync, active low, asynchronous
//   o_locked        out  1   timing locked
//   o_active        out  1   high on active pixels, gated by o_locked
//   o_x             out  10  active pixel x, 0..H_ACTIVE-1
//   o_y             out  9   active pixel y, 0..V_ACTIVE-1
//   o_line_len      out  10  last measured line period in strobes
//   o_frame_lines   out  10  last measured lines per frame
//   o_err           out  1   one-i_clk pulse on a timing mismatch
//   o_err_cnt       out  8   saturating mismatch count
// BEHAVIOUR
// - Reset (async, i_rst_n=0):
//   - Sync flops load 1 (idle level).
//   - Counters, o_line_len, o_frame_lines, o_err_cnt, good_cnt and h_valid load 0.
//   - State is SEARCH. All outputs are 0.
// - Input sync: i_hs and i_vs each pass through a 2-flop synchroniser advanced on i_pix_stb.
//   - A fall is sync stage 2 = 1 and stage 1 = 0 on a strobe.
//   - Pin-to-detect latency is 2 strobes.
// - h_cnt (10b):
//   - Loads 0 on the hs-fall strobe; otherwise increments each strobe.
//   - Saturates at 1023.
// - On hs fall:
//   - o_line_len <= h_cnt+1, saturating at 1023.
//   - h_valid <= 1.
//   - The measurement is ignored while h_valid=0, so the first edge after reset is not checked.
// - v_cnt (10b):
//   - Increments on each hs fall; saturates at 1023.
//   - On vs fall: o_frame_lines <= v_cnt, plus 1 if hs falls on the same strobe; then v_cnt <= 0.
// - FSM, evaluated on strobes only:
//   - SEARCH: on vs fall -> MEASURE, good_cnt=0. No checks, no o_err.
//   - MEASURE, line check: on a checked hs fall with line_len != LINE -> SEARCH, o_err.
//   - MEASURE, frame check: on vs fall with frame_lines != SCREEN -> SEARCH, o_err.
//     Otherwise good_cnt++, and when good_cnt reaches LOCK_FRAMES -> LOCKED.
//   - LOCKED: any line or frame mismatch -> SEARCH, o_err. o_locked is low from the next i_clk.
//   - A line mismatch and a frame mismatch on the same strobe give one o_err and one count.
// - o_locked is registered and high only in LOCKED.
// - Pixel outputs (combinational from the h_cnt/v_cnt registers):
//   - o_active = o_locked & HA_OFF <= h_cnt < HA_OFF+H_ACTIVE & VA_OFF <= v_cnt < VA_OFF+V_ACTIVE.
//   - When o_active=1: o_x = h_cnt-HA_OFF and o_y = v_cnt-VA_OFF.
//   - When o_active=0: o_x=0 and o_y=0.
// - o_err_cnt increments with each o_err pulse and holds at 255.
// - When i_pix_stb=0: all registers hold and o_err=0.
// TESTING
// - 4 frames of nominal timing (800x525, hs low 96, vs low 2 lines).
//   -> o_locked rises at the 3rd vs fall.
//   -> o_line_len=800, o_frame_lines=525, o_err_cnt=0.
// - Locked frame.
//   -> o_active first high at h_cnt=144 with o_x=0, o_y=0.
//   -> Last active pixel is o_x=639, o_y=359.
//   -> o_active is never high outside those bounds.
// - Locked, then one line of 799 strobes.
//   -> o_err pulses once, o_locked=0, o_err_cnt=1.
//   -> Relock after 2 clean frames, counted from the next vs fall.
// - Locked, then one frame of 524 lines.
//   -> o_frame_lines=524, unlock, o_err_cnt increments.
// - Reset pulsed mid-line with i_hs=1.
//   -> All outputs 0 immediately.
//   -> After release no spurious hs fall; first line unchecked (h_valid).
// - i_hs held high 2000 strobes.
//   -> h_cnt saturates at 1023, o_line_len unchanged, no o_err in SEARCH.

Source files
------------

// File: rtl/vga_sync_recovery.sv
// Recovers 640x480-style raster timing from incoming active-low HSYNC/VSYNC.
// Locks after LOCK_FRAMES clean frames and regenerates pixel x/y/active.
module vga_sync_recovery #(
  parameter int unsigned LINE        = 800,
  parameter int unsigned SCREEN      = 525,
  parameter int unsigned HA_OFF      = 144,
  parameter int unsigned VA_OFF      = 96,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 360,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_stb,
  input  logic        i_hs,
  input  logic        i_vs,
  output logic        o_locked,
  output logic        o_active,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic [9:0]  o_line_len,
  output logic [9:0]  o_frame_lines,
  output logic        o_err,
  output logic [7:0]  o_err_cnt
);

  localparam int unsigned CW = 10;
  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned EW = 8;
  localparam int unsigned GW = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  logic          hs_s1, hs_s2, vs_s1, vs_s2;
  logic          hs_fall, vs_fall;
  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_valid;
  logic [CW-1:0] line_meas, frame_meas, v_inc;
  logic          line_bad, frame_bad;
  state_t        state_q, state_d;
  logic [GW-1:0] good_cnt, good_d;
  logic          err_d;
  logic          h_in, v_in;

  // Edge detect on the synchronised sync lines; the strobe qualifies every event
  assign hs_fall = i_pix_stb & hs_s2 & ~hs_s1;
  assign vs_fall = i_pix_stb & vs_s2 & ~vs_s1;

  assign line_meas  = (h_cnt == '1) ? h_cnt : h_cnt + CW'(1);
  assign v_inc      = (v_cnt == '1) ? v_cnt : v_cnt + CW'(1);
  assign frame_meas = hs_fall ? v_inc : v_cnt;

  // Lines are only judged once a previous hs fall has given h_cnt a real origin
  assign line_bad  = hs_fall & h_valid & (line_meas != CW'(LINE));
  assign frame_bad = vs_fall & (frame_meas != CW'(SCREEN));

  // Synchronisers, raster counters and period measurements
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hs_s1         <= 1'b1;
      hs_s2         <= 1'b1;
      vs_s1         <= 1'b1;
      vs_s2         <= 1'b1;
      h_cnt         <= '0;
      v_cnt         <= '0;
      h_valid       <= 1'b0;
      o_line_len    <= '0;
      o_frame_lines <= '0;
    end else if (i_pix_stb) begin
      hs_s1 <= i_hs;
      hs_s2 <= hs_s1;
      vs_s1 <= i_vs;
      vs_s2 <= vs_s1;
      if (hs_fall) begin
        h_cnt      <= '0;
        o_line_len <= line_meas;
        h_valid    <= 1'b1;
      end else if (h_cnt != '1) begin
        h_cnt <= h_cnt + CW'(1);
      end
      if (vs_fall) begin
        o_frame_lines <= frame_meas;
        v_cnt         <= '0;
      end else if (hs_fall) begin
        v_cnt <= v_inc;
      end
    end
  end

  // Lock state machine: next state
  always_comb begin
    state_d = state_q;
    good_d  = good_cnt;
    err_d   = 1'b0;
    case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d = MEASURE;
          good_d  = '0;
        end
      end
      MEASURE: begin
        if (line_bad || frame_bad) begin
          state_d = SEARCH;
          err_d   = 1'b1;
        end else if (vs_fall) begin
          good_d = good_cnt + GW'(1);
          if (good_d == GW'(LOCK_FRAMES)) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (line_bad || frame_bad) begin
          state_d = SEARCH;
          err_d   = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Lock state machine: state and registered status outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= SEARCH;
      good_cnt  <= '0;
      o_locked  <= 1'b0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      state_q  <= state_d;
      good_cnt <= good_d;
      o_locked <= (state_d == LOCKED);
      o_err    <= err_d;
      if (err_d && (o_err_cnt != '1)) begin
        o_err_cnt <= o_err_cnt + EW'(1);
      end
    end
  end

  // Regenerated pixel coordinates, zeroed outside the active window
  assign h_in = (h_cnt >= CW'(HA_OFF)) && (h_cnt < CW'(HA_OFF + H_ACTIVE));
  assign v_in = (v_cnt >= CW'(VA_OFF)) && (v_cnt < CW'(VA_OFF + V_ACTIVE));

  assign o_active = o_locked & h_in & v_in;
  assign o_x      = o_active ? XW'(h_cnt - CW'(HA_OFF)) : '0;
  assign o_y      = o_active ? YW'(v_cnt - CW'(VA_OFF)) : '0;

endmodule
